// File: rtl/cnt_dn_reload.sv
// Loadable down-counting timer with a programmable prescaler.
// Counts a loaded value down to zero, then either stops (one-shot) or reloads (periodic).
module cnt_dn_reload #(
   parameter int n  = 4,
   parameter int PW = 4
) (
   input  logic          Clk,
   input  logic          resetn,
   input  logic          en,
   input  logic          ld,
   input  logic [n-1:0]  D,
   input  logic          mode,
   input  logic [PW-1:0] presc,
   output logic [n-1:0]  q,
   output logic          tc,
   output logic          busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [n-1:0] ONE = n'(1);

   state_t        state;
   logic [n-1:0]  rl;
   logic [PW-1:0] pc;

   // Load beats everything; the >= compare forces a tick if presc drops below pc.
   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         q     <= '0;
         rl    <= '0;
         pc    <= '0;
         tc    <= 1'b0;
         state <= IDLE;
      end else begin
         tc <= 1'b0;
         if (ld) begin
            q     <= D;
            rl    <= D;
            pc    <= '0;
            state <= (D != '0) ? RUN : IDLE;
         end else if (state == RUN && en) begin
            if (pc < presc) begin
               pc <= pc + PW'(1);
            end else begin
               pc <= '0;
               if (q > ONE) begin
                  q <= q - ONE;
               end else if (!mode) begin
                  q     <= '0;
                  tc    <= 1'b1;
                  state <= IDLE;
               end else begin
                  q  <= rl;
                  tc <= 1'b1;
               end
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_cnt_dn_reload.sv
// Directed table-driven bench for cnt_dn_reload with hand-computed expectations.
module tb_cnt_dn_reload;

   logic       Clk;
   logic       resetn;
   logic       en;
   logic       ld;
   logic [3:0] D;
   logic       mode;
   logic [3:0] presc;
   logic [3:0] q;
   logic       tc;
   logic       busy;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic       ld;
      logic       en;
      logic [3:0] d;
      logic       mode;
      logic [3:0] presc;
      logic [3:0] expQ;
      logic       expTc;
      logic       expBusy;
   } vec_t;

   vec_t vecs[$];

   cnt_dn_reload #(.n(4), .PW(4)) dut (
      .Clk(Clk), .resetn(resetn), .en(en), .ld(ld), .D(D), .mode(mode),
      .presc(presc), .q(q), .tc(tc), .busy(busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic void addVec(input logic l, input logic e, input logic [3:0] d,
                                  input logic m, input logic [3:0] p,
                                  input logic [3:0] eq, input logic etc, input logic eb);
      vec_t v;
      v.ld = l; v.en = e; v.d = d; v.mode = m; v.presc = p;
      v.expQ = eq; v.expTc = etc; v.expBusy = eb;
      vecs.push_back(v);
   endfunction

   // Drive inputs, take one rising edge, then settle before sampling.
   task automatic applyStimulus(input logic l, input logic e, input logic [3:0] d,
                                input logic m, input logic [3:0] p);
      ld = l; en = e; D = d; mode = m; presc = p;
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] eq,
                              input logic etc, input logic eb);
      checks++;
      if (q !== eq || tc !== etc || busy !== eb) begin
         fails++;
         $display("[TB] FAIL %s: got q=%0d tc=%0b busy=%0b, expected q=%0d tc=%0b busy=%0b",
                  tag, q, tc, busy, eq, etc, eb);
      end
   endtask

   initial begin
      // one-shot, D=3
      addVec(1,1,3,0,0, 3,0,1);
      addVec(0,1,0,0,0, 2,0,1);
      addVec(0,1,0,0,0, 1,0,1);
      addVec(0,1,0,0,0, 0,1,0);
      addVec(0,1,0,0,0, 0,0,0);
      addVec(0,1,0,0,0, 0,0,0);
      // periodic D=4 with a 3-cycle enable gap at q=2
      addVec(1,1,4,1,0, 4,0,1);
      addVec(0,1,0,1,0, 3,0,1);
      addVec(0,1,0,1,0, 2,0,1);
      addVec(0,1,0,1,0, 1,0,1);
      addVec(0,1,0,1,0, 4,1,1);
      addVec(0,1,0,1,0, 3,0,1);
      addVec(0,1,0,1,0, 2,0,1);
      addVec(0,0,0,1,0, 2,0,1);
      addVec(0,0,0,1,0, 2,0,1);
      addVec(0,0,0,1,0, 2,0,1);
      addVec(0,1,0,1,0, 1,0,1);
      addVec(0,1,0,1,0, 4,1,1);
      // prescaler 2, D=2, one-shot
      addVec(1,1,2,0,2, 2,0,1);
      addVec(0,1,0,0,2, 2,0,1);
      addVec(0,1,0,0,2, 2,0,1);
      addVec(0,1,0,0,2, 1,0,1);
      addVec(0,1,0,0,2, 1,0,1);
      addVec(0,1,0,0,2, 1,0,1);
      addVec(0,1,0,0,2, 0,1,0);
      // lowering presc below pc gives an immediate tick
      addVec(1,1,5,0,2, 5,0,1);
      addVec(0,1,0,0,2, 5,0,1);
      addVec(0,1,0,0,2, 5,0,1);
      addVec(0,1,0,0,0, 4,0,1);
      addVec(0,1,0,0,0, 3,0,1);
      // load priority over a terminal tick, and load with en=0
      addVec(1,1,2,1,0, 2,0,1);
      addVec(0,1,0,1,0, 1,0,1);
      addVec(1,1,13,1,0, 13,0,1);
      addVec(1,0,7,1,0, 7,0,1);
      addVec(0,0,0,1,0, 7,0,1);
      // zero load while running, then idle ignores en
      addVec(1,1,0,1,0, 0,0,0);
      addVec(0,1,0,1,0, 0,0,0);
      // periodic rl=1 presc=0: tc every cycle
      addVec(1,1,1,1,0, 1,0,1);
      addVec(0,1,0,1,0, 1,1,1);
      addVec(0,1,0,1,0, 1,1,1);
      addVec(1,1,0,0,0, 0,0,0);

      resetn = 1'b0; ld = 0; en = 0; D = 0; mode = 0; presc = 0;
      #1;
      checkOutput("reset_state", 0, 0, 0);
      #7 resetn = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ld, vecs[i].en, vecs[i].d, vecs[i].mode, vecs[i].presc);
         checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expTc, vecs[i].expBusy);
      end

      // max load: 15 decrements, tc exactly 15 edges after the load
      applyStimulus(1, 1, 15, 0, 0);
      checkOutput("max_load", 15, 0, 1);
      for (int j = 1; j < 15; j++) begin
         applyStimulus(0, 1, 0, 0, 0);
         checkOutput($sformatf("max_dec%0d", j), 4'(15 - j), 0, 1);
      end
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("max_tc", 0, 1, 0);

      // asynchronous reset mid-count, then no counting without a load
      applyStimulus(1, 1, 9, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("pre_reset", 8, 0, 1);
      #2 resetn = 1'b0;
      #1;
      checkOutput("async_reset", 0, 0, 0);
      #1 resetn = 1'b1;
      for (int j = 0; j < 10; j++) begin
         applyStimulus(0, 1, 9, 0, 0);
         checkOutput($sformatf("post_reset%0d", j), 0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
